// File: rtl/sine_table_arbiter.sv
// rtl/sine_table_arbiter.sv - round-robin sharing of one half-sine ROM between N_CH requesters
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   asynchronous, active-high
//   req_valid  in   per-channel request strobe
//   req_index  in   packed full-period indices, channel c at [c*IDX_W +: IDX_W]
//   req_ready  out  one-hot combinational grant
//   rom_en     out  registered ROM read enable
//   rom_addr   out  registered, folded ROM address
//   rom_data   in   ROM sample, valid the cycle after rom_en
//   rsp_valid  out  one-hot, one-cycle response pulse to the owning channel
//   rsp_data   out  sample accompanying rsp_valid, held otherwise
//   busy       out  an accepted request has not yet produced its response
module sine_table_arbiter #(
  parameter int N_CH       = 4,
  parameter int TABLE_SIZE = 32,
  parameter int ADDR_W     = 5,
  parameter int IDX_W      = 6,
  parameter int SINE_W     = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_CH-1:0]       req_valid,
  input  logic [N_CH*IDX_W-1:0] req_index,
  output logic [N_CH-1:0]       req_ready,
  output logic                  rom_en,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [SINE_W-1:0]     rom_data,
  output logic [N_CH-1:0]       rsp_valid,
  output logic [SINE_W-1:0]     rsp_data,
  output logic                  busy
);

  localparam int CH_W = $clog2(N_CH);

  logic [CH_W-1:0]   last_grant;
  logic [CH_W-1:0]   grant_ch;
  logic              grant_any;
  logic [IDX_W-1:0]  grant_index;
  logic [ADDR_W-1:0] fold_addr;

  // Stage 1 valid is rom_en itself; its tag travels alongside the ROM read.
  logic [CH_W-1:0]   s1_tag;
  logic              s2_valid;
  logic [CH_W-1:0]   s2_tag;

  // Round-robin search starting just after the last accepted channel.
  always_comb begin
    req_ready = '0;
    grant_ch  = '0;
    grant_any = 1'b0;
    for (int i = 1; i <= N_CH; i++) begin
      if (!grant_any && req_valid[(int'(last_grant) + i) % N_CH]) begin
        grant_any = 1'b1;
        grant_ch  = CH_W'((int'(last_grant) + i) % N_CH);
      end
    end
    if (grant_any) begin
      req_ready[grant_ch] = 1'b1;
    end
  end

  assign grant_index = req_index[grant_ch*IDX_W +: IDX_W];

  // Second half of the period walks the half table backwards.
  always_comb begin
    if (int'(grant_index) < TABLE_SIZE) begin
      fold_addr = grant_index[ADDR_W-1:0];
    end else begin
      fold_addr = ADDR_W'(2*TABLE_SIZE - 1 - int'(grant_index));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= CH_W'(N_CH - 1);
      rom_en     <= 1'b0;
      rom_addr   <= '0;
      s1_tag     <= '0;
      s2_valid   <= 1'b0;
      s2_tag     <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
    end else begin
      // Stage 1: issue the ROM read for this cycle's acceptance.
      rom_en <= grant_any;
      if (grant_any) begin
        last_grant <= grant_ch;
        rom_addr   <= fold_addr;
        s1_tag     <= grant_ch;
      end
      // Stage 2: the ROM is presenting data for the stage-1 read.
      s2_valid <= rom_en;
      s2_tag   <= s1_tag;
      // Output: capture the sample and route the pulse to its owner.
      rsp_valid <= '0;
      if (s2_valid) begin
        rsp_valid[s2_tag] <= 1'b1;
        rsp_data          <= rom_data;
      end
    end
  end

  assign busy = rom_en | s2_valid;

endmodule

// File: tb/tb_sine_table_arbiter.sv
// tb/tb_sine_table_arbiter.sv - directed scoreboard bench for sine_table_arbiter
module tb_sine_table_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [23:0] req_index = '0;
  logic [3:0]  req_ready;
  logic        rom_en;
  logic [4:0]  rom_addr;
  logic [7:0]  rom_data = '0;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        busy;

  sine_table_arbiter dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_index(req_index), .req_ready(req_ready),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clock = ~clock;

  // Synchronous ROM model: sample = addr*2, one cycle after the read.
  always @(posedge clock) if (rom_en) rom_data <= {rom_addr, 1'b0};

  typedef struct { int ch; int data; int due; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_last = 3;
  int last_rsp = 0;

  function automatic int fold(input int k);
    return (k < 32) ? k : 63 - k;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare this cycle's response outputs against the head of the scoreboard.
  task automatic check_rsp();
    if (sb.size() != 0 && sb[0].due == cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk("rsp_valid", 32'(rsp_valid), 32'(1 << e.ch));
      chk("rsp_data", 32'(rsp_data), 32'(e.data));
      last_rsp = e.data;
    end else begin
      chk("rsp_idle", 32'(rsp_valid), 32'd0);
      chk("rsp_hold", 32'(rsp_data), 32'(last_rsp));
    end
  endtask

  // One clock of stimulus: drive, check grant, clock, check ROM/response/busy.
  task automatic cycle(input logic [3:0] v, input logic [23:0] idx);
    int g;
    int k;
    req_valid = v;
    req_index = idx;
    #1;
    g = -1;
    for (int i = 1; i <= 4; i++) begin
      if (g < 0 && v[(exp_last + i) % 4]) g = (exp_last + i) % 4;
    end
    chk("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : 32'(1 << g));
    k = (g < 0) ? 0 : int'(idx[g*6 +: 6]);
    @(posedge clock);
    cyc++;
    #1;
    req_valid = '0;
    check_rsp();
    chk("rom_en", 32'(rom_en), (g < 0) ? 32'd0 : 32'd1);
    if (g >= 0) begin
      chk("rom_addr", 32'(rom_addr), 32'(fold(k)));
      sb.push_back('{ch: g, data: fold(k) * 2, due: cyc + 2});
      exp_last = g;
    end
    chk("busy", 32'(busy), (sb.size() != 0) ? 32'd1 : 32'd0);
  endtask

  // Assert reset away from a clock edge; outputs must clear at once.
  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    #1;
    sb.delete();
    exp_last = 3;
    last_rsp = 0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rom_en", 32'(rom_en), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #3;
    // Reset state
    do_reset();
    chk("rst_req_ready", 32'(req_ready), 32'd0);

    // Single channel: ch0 k=5
    cycle(4'b0001, {6'd0, 6'd0, 6'd0, 6'd5});
    repeat (3) cycle(4'b0000, '0);

    // Fold boundaries on ch1
    cycle(4'b0010, {6'd0, 6'd0, 6'd0, 6'd0});
    cycle(4'b0010, {6'd0, 6'd0, 6'd31, 6'd0});
    cycle(4'b0010, {6'd0, 6'd0, 6'd32, 6'd0});
    cycle(4'b0010, {6'd0, 6'd0, 6'd63, 6'd0});
    repeat (3) cycle(4'b0000, '0);

    // Round-robin fairness from a fresh pointer
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(4'b1111, {6'(40 + i), 6'(20 + i), 6'(10 + 3 * i), 6'(i)});
    end
    repeat (3) cycle(4'b0000, '0);

    // Sparse contention: ch2+ch3, then ch0 joins
    do_reset();
    cycle(4'b1100, {6'd50, 6'd2, 6'd0, 6'd0});
    cycle(4'b1100, {6'd50, 6'd2, 6'd0, 6'd0});
    cycle(4'b1101, {6'd50, 6'd2, 6'd0, 6'd33});
    cycle(4'b1101, {6'd50, 6'd2, 6'd0, 6'd33});
    repeat (3) cycle(4'b0000, '0);

    // Reset mid-flight: ch3 k=40 is discarded
    cycle(4'b1000, {6'd40, 6'd0, 6'd0, 6'd0});
    cycle(4'b0000, '0);
    do_reset();
    repeat (4) cycle(4'b0000, '0);
    cycle(4'b1111, {6'd1, 6'd2, 6'd3, 6'd60});
    repeat (3) cycle(4'b0000, '0);

    // Idle: ten quiet cycles after a completed transaction
    cycle(4'b0100, {6'd0, 6'd17, 6'd0, 6'd0});
    repeat (10) cycle(4'b0000, '0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
